pic_control_sequencer: RTL and testbench

- Synchronous control block for the 8259-style interrupt block (IRR / priority resolver / ISR).
- Decodes CPU register writes into the ICW1–ICW4 initialization sequence and the OCW1/OCW2 operation commands.
- Drives the interrupt block's configuration inputs: level/edge select, mask, rotation set/reset, AEOI and EOI.
- Sequences the two-pulse INTA handshake and returns the interrupt vector.

---
 rtl/pic_control_sequencer.sv | 163 ++++++++++++++++
 tb/tb_pic_control_sequencer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/pic_control_sequencer.sv
// Control sequencer for an 8259-style interrupt block: decodes the ICW/OCW
// register writes, drives the interrupt block's configuration and runs the INTA handshake.
module pic_control_sequencer #(
   parameter int VEC_LOW_BITS = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       wr_strobe,
   input  logic       a0,
   input  logic [7:0] din,
   input  logic       inta_pulse,
   input  logic       int_req,
   input  logic [2:0] isr_level,
   output logic       int_out,
   output logic [1:0] intA_counter,
   output logic       level_or_edge_flag,
   output logic [7:0] mask,
   output logic       set,
   output logic       rot_reset,
   output logic       aeoi,
   output logic       eoi,
   output logic [7:0] vector_out,
   output logic       vector_valid,
   output logic       init_done
);

   localparam int BASE_W = 8 - VEC_LOW_BITS;

   typedef enum logic [2:0] {
      UNINIT,
      W_ICW2,
      W_ICW3,
      W_ICW4,
      READY
   } state_t;

   state_t state;
   state_t state_next;

   logic [BASE_W-1:0]       base;
   logic                    single;
   logic                    ic4;
   logic [1:0]              counter_next;
   logic                    vec_fire;
   logic [VEC_LOW_BITS-1:0] vec_low;

   logic icw1_wr;
   logic data_wr;
   logic ocw2_wr;

   // ICW1 is recognised in every state and overrides anything else in its cycle.
   assign icw1_wr = wr_strobe && !a0 && din[4];
   assign data_wr = wr_strobe && a0;
   assign ocw2_wr = wr_strobe && !a0 && (din[4:3] == 2'b00) && (state == READY);
   assign vec_low = VEC_LOW_BITS'(isr_level);

   assign init_done = (state == READY);
   assign int_out   = (state == READY) && int_req && (intA_counter == 2'b00);

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= UNINIT;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next   = state;
      counter_next = intA_counter;
      vec_fire     = 1'b0;

      if (icw1_wr) begin
         state_next   = W_ICW2;
         counter_next = 2'b00;
      end else begin
         unique case (state)
            W_ICW2: begin
               if (data_wr) begin
                  if (!single)  state_next = W_ICW3;
                  else if (ic4) state_next = W_ICW4;
                  else          state_next = READY;
               end
            end
            W_ICW3: begin
               if (data_wr) state_next = ic4 ? W_ICW4 : READY;
            end
            W_ICW4: begin
               if (data_wr) state_next = READY;
            end
            default: begin
            end
         endcase

         // The INTA handshake only advances once initialisation is complete.
         if (state == READY) begin
            unique case (intA_counter)
               2'b00: if (inta_pulse) counter_next = 2'b01;
               2'b01: begin
                  if (inta_pulse) begin
                     counter_next = 2'b10;
                     vec_fire     = 1'b1;
                  end
               end
               default: counter_next = 2'b00;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         base               <= '0;
         single             <= 1'b0;
         ic4                <= 1'b0;
         level_or_edge_flag <= 1'b0;
         mask               <= 8'h00;
         set                <= 1'b0;
         rot_reset          <= 1'b1;
         aeoi               <= 1'b0;
         eoi                <= 1'b0;
         intA_counter       <= 2'b00;
         vector_out         <= 8'h00;
         vector_valid       <= 1'b0;
      end else begin
         eoi          <= 1'b0;
         vector_valid <= 1'b0;
         intA_counter <= counter_next;

         if (icw1_wr) begin
            level_or_edge_flag <= din[3];
            single             <= din[1];
            ic4                <= din[0];
            mask               <= 8'h00;
            aeoi               <= 1'b0;
            set                <= 1'b0;
            rot_reset          <= 1'b1;
         end else begin
            if (data_wr && (state == W_ICW2)) base <= din[7:VEC_LOW_BITS];
            if (data_wr && (state == W_ICW4)) aeoi <= din[1];
            if (data_wr && (state == READY))  mask <= din;

            // OCW2: din[5] is the non-specific EOI, din[7] selects rotation.
            if (ocw2_wr) begin
               eoi <= din[5];
               if (din[7]) begin
                  set       <= 1'b1;
                  rot_reset <= 1'b0;
               end else if (din[7:5] == 3'b000) begin
                  set       <= 1'b0;
                  rot_reset <= 1'b1;
               end
            end
         end

         if (vec_fire) begin
            vector_out   <= {base, vec_low};
            vector_valid <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_pic_control_sequencer.sv
// Directed bench for pic_control_sequencer: init sequences, OCW decode,
// INTA handshake, ICW1 abort and mid-sequence reset.
module tb_pic_control_sequencer;

   logic       clk = 1'b0;
   logic       reset;
   logic       wr_strobe;
   logic       a0;
   logic [7:0] din;
   logic       inta_pulse;
   logic       int_req;
   logic [2:0] isr_level;
   logic       int_out;
   logic [1:0] intA_counter;
   logic       level_or_edge_flag;
   logic [7:0] mask;
   logic       set;
   logic       rot_reset;
   logic       aeoi;
   logic       eoi;
   logic [7:0] vector_out;
   logic       vector_valid;
   logic       init_done;

   int n_assert = 0;
   int n_fail   = 0;

   pic_control_sequencer #(.VEC_LOW_BITS(3)) dut (
      .clk                (clk),
      .reset              (reset),
      .wr_strobe          (wr_strobe),
      .a0                 (a0),
      .din                (din),
      .inta_pulse         (inta_pulse),
      .int_req            (int_req),
      .isr_level          (isr_level),
      .int_out            (int_out),
      .intA_counter       (intA_counter),
      .level_or_edge_flag (level_or_edge_flag),
      .mask               (mask),
      .set                (set),
      .rot_reset          (rot_reset),
      .aeoi               (aeoi),
      .eoi                (eoi),
      .vector_out         (vector_out),
      .vector_valid       (vector_valid),
      .init_done          (init_done)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic a, input logic [7:0] d);
      wr_strobe = 1'b1;
      a0        = a;
      din       = d;
      tick();
      wr_strobe = 1'b0;
      a0        = 1'b0;
      din       = 8'h00;
   endtask

   task automatic pulse_inta();
      inta_pulse = 1'b1;
      tick();
      inta_pulse = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; wr_strobe = 1'b0; a0 = 1'b0; din = 8'h00;
      inta_pulse = 1'b0; int_req = 1'b0; isr_level = 3'd0;
      tick(); tick();
      reset = 1'b0;

      // Reset state
      chk("rst_init_done", {7'd0, init_done}, 8'h00);
      chk("rst_rot_reset", {7'd0, rot_reset}, 8'h01);
      chk("rst_mask", mask, 8'h00);
      chk("rst_counter", {6'd0, intA_counter}, 8'h00);
      chk("rst_set_aeoi_eoi", {5'd0, set, aeoi, eoi}, 8'h00);
      chk("rst_vec", {vector_valid, vector_out[6:0]}, 8'h00);
      chk("rst_int_out_level", {6'd0, int_out, level_or_edge_flag}, 8'h00);

      // Single mode with ICW4: ICW3 skipped
      wr(1'b0, 8'h13);
      chk("t1_icw1_not_ready", {7'd0, init_done}, 8'h00);
      wr(1'b1, 8'h40);
      chk("t1_icw2_not_ready", {7'd0, init_done}, 8'h00);
      wr(1'b1, 8'h02);
      chk("t1_ready", {7'd0, init_done}, 8'h01);
      chk("t1_aeoi", {7'd0, aeoi}, 8'h01);
      chk("t1_level", {7'd0, level_or_edge_flag}, 8'h00);

      // INTA handshake, base 01000, level 5
      int_req = 1'b1; isr_level = 3'd5;
      #1;
      chk("t3_int_out_hi", {7'd0, int_out}, 8'h01);
      pulse_inta();
      chk("t3_cnt01", {6'd0, intA_counter}, 8'h01);
      chk("t3_int_out_lo", {7'd0, int_out}, 8'h00);
      chk("t3_no_valid", {7'd0, vector_valid}, 8'h00);
      pulse_inta();
      chk("t3_cnt10", {6'd0, intA_counter}, 8'h02);
      chk("t3_valid", {7'd0, vector_valid}, 8'h01);
      chk("t3_vector", vector_out, 8'h45);
      pulse_inta();
      chk("t3_cnt00", {6'd0, intA_counter}, 8'h00);
      chk("t3_valid_drop", {7'd0, vector_valid}, 8'h00);
      chk("t3_vector_hold", vector_out, 8'h45);
      chk("t3_int_out_again", {7'd0, int_out}, 8'h01);

      // OCW1 / OCW2
      int_req = 1'b0;
      wr(1'b1, 8'hA5);
      chk("t4_mask", mask, 8'hA5);
      wr(1'b0, 8'h20);
      chk("t4_eoi_hi", {7'd0, eoi}, 8'h01);
      tick();
      chk("t4_eoi_lo", {7'd0, eoi}, 8'h00);
      wr(1'b0, 8'h80);
      chk("t4_rot_on", {6'd0, set, rot_reset}, 8'h02);
      wr(1'b0, 8'h00);
      chk("t4_rot_off", {6'd0, set, rot_reset}, 8'h01);
      wr(1'b0, 8'h08);
      chk("t4_ocw3_noop", {5'd0, set, rot_reset, eoi}, 8'h02);
      chk("t4_ocw3_mask", mask, 8'hA5);

      // Non-ICW1 write together with INTA: both take effect
      int_req = 1'b1;
      inta_pulse = 1'b1;
      wr(1'b1, 8'h3C);
      inta_pulse = 1'b0;
      chk("t5_mask_with_inta", mask, 8'h3C);
      chk("t5_cnt_with_wr", {6'd0, intA_counter}, 8'h01);

      // ICW1 together with INTA aborts the handshake
      inta_pulse = 1'b1;
      wr(1'b0, 8'h1A);
      inta_pulse = 1'b0;
      chk("t5_abort_cnt", {6'd0, intA_counter}, 8'h00);
      chk("t5_abort_valid", {7'd0, vector_valid}, 8'h00);
      chk("t5_abort_mask", mask, 8'h00);
      chk("t5_abort_not_ready", {7'd0, init_done}, 8'h00);
      chk("t5_abort_int_out", {7'd0, int_out}, 8'h00);
      chk("t5_abort_level", {7'd0, level_or_edge_flag}, 8'h01);
      wr(1'b0, 8'h08);
      chk("t5_ignore_a0_0", {7'd0, init_done}, 8'h00);
      wr(1'b1, 8'h20);
      chk("t5_ready_after_icw2", {7'd0, init_done}, 8'h01);

      // Cascade mode without ICW4: three writes
      int_req = 1'b0;
      wr(1'b0, 8'h18);
      chk("t2_icw1_level", {7'd0, level_or_edge_flag}, 8'h01);
      wr(1'b0, 8'h08);
      chk("t2_ignored_wr", {7'd0, init_done}, 8'h00);
      chk("t2_ignored_mask", mask, 8'h00);
      wr(1'b1, 8'h20);
      chk("t2_icw3_wait", {7'd0, init_done}, 8'h00);
      wr(1'b0, 8'h00);
      chk("t2_ignored_icw3", {7'd0, init_done}, 8'h00);
      wr(1'b1, 8'h00);
      chk("t2_ready", {7'd0, init_done}, 8'h01);
      chk("t2_aeoi", {7'd0, aeoi}, 8'h00);

      // Vector with base 00100, level 3
      int_req = 1'b1; isr_level = 3'd3;
      pulse_inta();
      pulse_inta();
      chk("t2_vector", vector_out, 8'h23);
      chk("t2_valid", {7'd0, vector_valid}, 8'h01);
      tick();

      // Reset mid-sequence
      pulse_inta();
      chk("t6_cnt01", {6'd0, intA_counter}, 8'h01);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("t6_rst_cnt", {6'd0, intA_counter}, 8'h00);
      chk("t6_rst_init_done", {7'd0, init_done}, 8'h00);
      chk("t6_rst_rot", {6'd0, set, rot_reset}, 8'h01);
      chk("t6_rst_level", {6'd0, level_or_edge_flag, int_out}, 8'h00);
      chk("t6_rst_vector", vector_out, 8'h00);
      pulse_inta();
      chk("t6_uninit_inta", {6'd0, intA_counter}, 8'h00);
      chk("t6_uninit_int_out", {7'd0, int_out}, 8'h00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
